// File: rtl/fc_argmax_pkg.sv
// Shared types and helpers for the fully-connected layer argmax output stage.
package fc_argmax_pkg;

  typedef enum logic {S_ACC, S_OUT} argmax_state_t;

  // Index width for an M-element vector; one bit minimum so M==1 still has a port.
  function automatic int idx_width(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/argmax_cmp.sv
// Combinational signed compare/select of a candidate (value, index) against the running best.
// Strictly-greater replaces the best, so ties keep the earlier (lower) index.
module argmax_cmp #(
  parameter int T     = 12,
  parameter int IDX_W = 3
) (
  input  logic signed [T-1:0]     cand_val,
  input  logic        [IDX_W-1:0] cand_idx,
  input  logic signed [T-1:0]     best_val,
  input  logic        [IDX_W-1:0] best_idx,
  output logic signed [T-1:0]     new_val,
  output logic        [IDX_W-1:0] new_idx
);

  logic take_cand;

  assign take_cand = cand_val > best_val;
  assign new_val   = take_cand ? cand_val : best_val;
  assign new_idx   = take_cand ? cand_idx : best_idx;

endmodule

// File: rtl/fc_argmax_out.sv
// Argmax of each M-element signed vector; result valid the cycle after the M-th accept.
// Input stalls while a result waits for output_ready. Optional output_score port via ARGMAX_SCORE_EN.
module fc_argmax_out
  import fc_argmax_pkg::*;
#(
  parameter  int M     = 6,
  parameter  int T     = 12,
  localparam int IDX_W = idx_width(M)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 input_valid,
  output logic                 input_ready,
  input  logic signed [T-1:0]  input_data,
  output logic                 output_valid,
  input  logic                 output_ready,
  output logic [IDX_W-1:0]     output_data
`ifdef ARGMAX_SCORE_EN
  ,
  output logic signed [T-1:0]  output_score
`endif
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(M - 1);

  argmax_state_t       state;
  logic [IDX_W-1:0]    count;
  logic [IDX_W-1:0]    best_idx;
  logic signed [T-1:0] best_val;
  logic [IDX_W-1:0]    cmp_idx;
  logic signed [T-1:0] cmp_val;
  logic [IDX_W-1:0]    sel_idx;
  logic signed [T-1:0] sel_val;
  logic                accept;

  argmax_cmp #(
    .T     (T),
    .IDX_W (IDX_W)
  ) u_cmp (
    .cand_val (input_data),
    .cand_idx (count),
    .best_val (best_val),
    .best_idx (best_idx),
    .new_val  (cmp_val),
    .new_idx  (cmp_idx)
  );

  // The first element of a vector seeds the best pair regardless of the stale register.
  assign sel_val = (count == '0) ? input_data : cmp_val;
  assign sel_idx = (count == '0) ? '0         : cmp_idx;

  assign input_ready  = (state == S_ACC);
  assign output_valid = (state == S_OUT);
  assign output_data  = best_idx;
  assign accept       = input_valid && input_ready;

`ifdef ARGMAX_SCORE_EN
  assign output_score = best_val;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_ACC;
      count    <= '0;
      best_idx <= '0;
      best_val <= '0;
    end else begin
      case (state)
        S_ACC: begin
          if (accept) begin
            best_val <= sel_val;
            best_idx <= sel_idx;
            if (count == LAST) begin
              count <= '0;
              state <= S_OUT;
            end else begin
              count <= count + IDX_W'(1);
            end
          end
        end
        S_OUT: begin
          if (output_ready) state <= S_ACC;
        end
        default: state <= S_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_argmax_out.sv
// Directed bench for fc_argmax_out (M=6, T=12); also checks output_score when ARGMAX_SCORE_EN is defined.
module tb_fc_argmax_out;

  localparam int M = 6;
  localparam int T = 12;

  logic                clk = 1'b0;
  logic                reset;
  logic                input_valid;
  logic                input_ready;
  logic signed [T-1:0] input_data;
  logic                output_valid;
  logic                output_ready;
  logic [2:0]          output_data;
`ifdef ARGMAX_SCORE_EN
  logic signed [T-1:0] output_score;
`endif

  int n_asserts = 0;
  int n_fails   = 0;

  fc_argmax_out #(.M(M), .T(T)) dut (
    .clk          (clk),
    .reset        (reset),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .input_data   (input_data),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_data  (output_data)
`ifdef ARGMAX_SCORE_EN
    ,
    .output_score (output_score)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Offer one element; it is accepted on the next posedge where input_ready is high.
  task automatic push(input logic signed [T-1:0] v);
    int n;
    n = 0;
    @(negedge clk);
    input_valid = 1'b1;
    input_data  = v;
    while (!input_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("push_timeout", 1, 0);
    @(posedge clk);
    #1;
    input_valid = 1'b0;
  endtask

  // Push a full vector, optionally with idle gaps, confirming no early result.
  task automatic push_vec(input string tag, input logic signed [T-1:0] v [M], input int max_gap);
    for (int i = 0; i < M; i++) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
      push(v[i]);
      if (i < M - 1) check({tag, "_no_early_valid"}, 32'(output_valid), 0);
    end
  endtask

  // Result must be present right after the last accept; then take it.
  task automatic expect_result(input string tag, input int idx, input int score);
    check({tag, "_valid"}, 32'(output_valid), 1);
    check({tag, "_idx"}, 32'(output_data), idx);
`ifdef ARGMAX_SCORE_EN
    check({tag, "_score"}, 32'(output_score), score);
`else
    if (score == -9999) check({tag, "_score_unused"}, 0, 1);
`endif
    check({tag, "_in_rdy_low"}, 32'(input_ready), 0);
    @(negedge clk);
    output_ready = 1'b1;
    @(posedge clk);
    #1;
    output_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(output_valid), 0);
    check({tag, "_in_rdy_back"}, 32'(input_ready), 1);
  endtask

  logic signed [T-1:0] v1 [M] = '{12'sd23, 12'sd9, 12'sd20, -12'sd14, -12'sd10, 12'sd29};
  logic signed [T-1:0] v2 [M] = '{-12'sd30, -12'sd4, -12'sd13, -12'sd4, -12'sd14, -12'sd32};
  logic signed [T-1:0] v3 [M] = '{12'sd1, 12'sd2, 12'sd3, 12'sd4, 12'sd5, 12'sd6};
  logic signed [T-1:0] v4 [M] = '{12'sd14, -12'sd21, 12'sd2, -12'sd26, 12'sd22, 12'sd23};
  logic signed [T-1:0] v5 [M] = '{12'sd0, 12'sd0, 12'sd0, 12'sd0, 12'sd7, 12'sd0};

  initial begin
    reset        = 1'b0;
    input_valid  = 1'b0;
    input_data   = '0;
    output_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_rdy", 32'(input_ready), 1);
    check("reset_out_vld", 32'(output_valid), 0);
    check("reset_out_dat", 32'(output_data), 0);
`ifdef ARGMAX_SCORE_EN
    check("reset_score", 32'(output_score), 0);
`endif
    @(negedge clk);
    reset = 1'b1;

    // Gap-free vector, max at the last element.
    push_vec("v1", v1, 0);
    expect_result("v1", 5, 29);

    // All-negative with a tie: earlier index of -4 wins.
    push_vec("v2", v2, 0);
    // Backpressure: result holds, extra input pulses are refused.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      input_valid = 1'b1;
      input_data  = 12'sd100;
      @(posedge clk);
      #1;
      check("bp_valid", 32'(output_valid), 1);
      check("bp_idx", 32'(output_data), 1);
      check("bp_in_rdy", 32'(input_ready), 0);
    end
    @(negedge clk);
    input_valid = 1'b0;
    expect_result("v2", 1, -4);

    push_vec("v3", v3, 0);
    expect_result("v3", 5, 6);

    // Idle gaps between elements, plus a stray output_ready while no result is pending.
    @(negedge clk);
    output_ready = 1'b1;
    @(posedge clk);
    #1;
    output_ready = 1'b0;
    check("stray_ordy_in_rdy", 32'(input_ready), 1);
    push_vec("v4", v4, 3);
    expect_result("v4", 5, 23);

    // Reset mid-vector discards the partial vector.
    push(12'sd30);
    push(12'sd1);
    push(12'sd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_in_rdy", 32'(input_ready), 1);
    check("midrst_out_vld", 32'(output_valid), 0);
    check("midrst_out_dat", 32'(output_data), 0);
    @(negedge clk);
    reset = 1'b1;
    push_vec("v5", v5, 0);
    expect_result("v5", 4, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
